adc_capture_sequencer: RTL and testbench
========================================

Name: adc_capture_sequencer

Overview:
- Sequences waveform capture of the ADC processing datapath output into a circular sample buffer, all in the ADC clock domain.
- Qualifies a trigger from the threshold detector (adcUseThisSample and adcExceedsThreshold) or from a software force.
- Generates buffer write enables and addresses with programmable pre-trigger and post-trigger depths, then reports the trigger address and completion.
- Sits between the ADC processing outputs and the capture buffer RAM; arm, force and config are already synchronised into adcClk upstream.

Parameters:
ADDR_WIDTH, 10, capture buffer address width; depth D = 2^ADDR_WIDTH
HOLDOFF_WIDTH, 16, width of the auto-rearm holdoff counter

Ports:
adcClk  in  1  ADC clock; the only clock
adcReset_n  in  1  asynchronous, active-low reset
arm  in  1  single-cycle pulse: latch config and start a capture
abort  in  1  single-cycle pulse: return to IDLE
forceTrigger  in  1  software trigger; honoured in ARMED only
preCount  in  ADDR_WIDTH  samples to keep before the trigger
postCount  in  ADDR_WIDTH  samples to write after the trigger sample
holdoff  in  HOLDOFF_WIDTH  adcClk cycles between DONE and auto-rearm
adcValidOut  in  1  sample strobe from ADC processing
adcUseThisSample  in  1  sample qualifier from ADC processing
adcExceedsThreshold  in  1  threshold flag from ADC processing
captureWrEn  out  1  buffer write enable
captureAddr  out  ADDR_WIDTH  buffer write address
triggerAddr  out  ADDR_WIDTH  address where the trigger sample was written
busy  out  1  high in PREFILL, ARMED, POST
done  out  1  level; high in DONE
donePulse  out  1  one-cycle pulse on entry to DONE
forced  out  1  1 if the last trigger came from forceTrigger

Behaviour:
- Reset: all outputs 0, state IDLE, write pointer 0.
- All outputs are registered.
- captureWrEn = adcValidOut registered (1-cycle latency), gated by state.
- captureAddr is the pointer value for that write; the pointer increments after each write and wraps D-1 -> 0.
- Config latched on arm, with clamping:
  - post = min(postCount, D-1)
  - pre = min(preCount, D-1-post)
- States and transitions:
  - IDLE: no writes. arm -> PREFILL, pointer kept, fill counter cleared.
  - PREFILL: writes every valid sample, counting them. When count reaches pre (immediately if pre=0) -> ARMED. Triggers are ignored.
  - ARMED: writes every valid sample. A trigger is (adcValidOut & adcUseThisSample & adcExceedsThreshold) | forceTrigger.
    - The trigger sample is written; triggerAddr = its address; forced is set per trigger source.
    - If post=0 -> DONE, else -> POST.
    - forceTrigger without adcValidOut: triggerAddr = next write address; no write that cycle.
  - POST: writes valid samples. After post writes -> DONE.
  - DONE: no writes; done=1; donePulse for 1 cycle on entry.
    - Macro absent: an arm pulse re-arms (-> PREFILL).
- abort in any state -> IDLE next cycle; pointer and triggerAddr retained; no donePulse.
- Simultaneous arm and abort: abort wins.
- arm while busy is ignored.
- A trigger coincident with the PREFILL->ARMED transition cycle is ignored.
- Asynchronous reset mid-capture: immediate return to reset values; no partial done.

Optional Feature:
- Macro ADC_CAPTURE_AUTO_REARM_EN.
- Defined: on DONE, load the holdoff counter. Count it down each cycle while done stays high, then auto-enter PREFILL with the same latched config.
  - holdoff=0 re-arms on the next cycle.
  - An arm pulse in DONE re-arms immediately.
  - abort during holdoff -> IDLE.
- Undefined: DONE persists until arm, abort or reset; holdoff input unused.

Test Plan:
- Reset then idle with adcValidOut toggling -> captureWrEn stays 0, all outputs 0.
- D=1024, pre=4, post=3, valid every cycle, threshold at the 10th sample after arm.
  - Writes at addresses 0..12; triggerAddr=9; donePulse 1 cycle after the write to addr 12; forced=0.
- Threshold asserted during PREFILL (pre=8, trigger at sample 3) -> ignored; the first qualified trigger after 8 samples is taken.
- forceTrigger in ARMED with adcValidOut=0, post=0 -> DONE next cycle, forced=1, no extra write.
- Pointer wrap: start pointer 1020, pre=2, post=5 -> addresses 1020..1023, 0..3 with no gap.
  - Clamp case: pre=1000, post=1000 -> post=1000, pre=23.
- abort mid-POST -> IDLE next cycle, no donePulse.
  - With ADC_CAPTURE_AUTO_REARM_EN and holdoff=5: busy reasserts exactly 6 cycles after donePulse.

Source files
------------

// File: rtl/adc_capture_sequencer.sv
// Capture sequencer: pre/post-trigger write control for the ADC sample ring buffer.
// Optional auto-rearm after a holdoff when ADC_CAPTURE_AUTO_REARM_EN is defined.
module adc_capture_sequencer #(
    parameter int ADDR_WIDTH    = 10,
    parameter int HOLDOFF_WIDTH = 16
) (
    input  logic                     adcClk,
    input  logic                     adcReset_n,
    input  logic                     arm,
    input  logic                     abort,
    input  logic                     forceTrigger,
    input  logic [ADDR_WIDTH-1:0]    preCount,
    input  logic [ADDR_WIDTH-1:0]    postCount,
    input  logic [HOLDOFF_WIDTH-1:0] holdoff,
    input  logic                     adcValidOut,
    input  logic                     adcUseThisSample,
    input  logic                     adcExceedsThreshold,
    output logic                     captureWrEn,
    output logic [ADDR_WIDTH-1:0]    captureAddr,
    output logic [ADDR_WIDTH-1:0]    triggerAddr,
    output logic                     busy,
    output logic                     done,
    output logic                     donePulse,
    output logic                     forced
);

    typedef enum logic [2:0] {IDLE, PREFILL, ARMED, POST, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

    state_t                  state, state_nx;
    logic [ADDR_WIDTH-1:0]   ptr, cnt, cnt_nx, cnt_inc;
    logic [ADDR_WIDTH-1:0]   pre_q, post_q, pre_c, room;
    logic                    wr, trig, latch, qual, enter_done;

    assign qual    = adcValidOut & adcUseThisSample & adcExceedsThreshold;
    // room left for pre-trigger samples once post and the trigger are reserved
    assign room    = ~postCount;
    assign pre_c   = (preCount > room) ? room : preCount;
    assign cnt_inc = cnt + {{(ADDR_WIDTH-1){1'b0}}, adcValidOut};

`ifdef ADC_CAPTURE_AUTO_REARM_EN
    localparam logic [HOLDOFF_WIDTH-1:0] HONE = HOLDOFF_WIDTH'(1);
    logic [HOLDOFF_WIDTH-1:0] hold;
`else
    logic unused_holdoff;
    assign unused_holdoff = ^holdoff;
`endif

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        wr       = 1'b0;
        trig     = 1'b0;
        latch    = 1'b0;
        unique case (state)
            IDLE: begin
                if (arm) begin
                    latch    = 1'b1;
                    cnt_nx   = '0;
                    state_nx = PREFILL;
                end
            end
            PREFILL: begin
                wr     = adcValidOut;
                cnt_nx = cnt_inc;
                if (cnt_inc >= pre_q) state_nx = ARMED;
            end
            ARMED: begin
                wr   = adcValidOut;
                trig = qual | forceTrigger;
                if (trig) begin
                    cnt_nx   = '0;
                    state_nx = (post_q == '0) ? DONE : POST;
                end
            end
            POST: begin
                wr     = adcValidOut;
                cnt_nx = cnt_inc;
                if (cnt_inc == post_q) state_nx = DONE;
            end
            DONE: begin
                if (arm) begin
                    latch    = 1'b1;
                    cnt_nx   = '0;
                    state_nx = PREFILL;
                end
`ifdef ADC_CAPTURE_AUTO_REARM_EN
                else if (hold == '0) begin
                    cnt_nx   = '0;
                    state_nx = PREFILL;
                end
`endif
            end
            default: state_nx = IDLE;
        endcase
        // abort beats everything, including a same-cycle arm or write
        if (abort) begin
            state_nx = IDLE;
            wr       = 1'b0;
            trig     = 1'b0;
            latch    = 1'b0;
        end
    end

    assign enter_done = (state_nx == DONE) && (state != DONE);

    always_ff @(posedge adcClk or negedge adcReset_n) begin
        if (!adcReset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            ptr         <= '0;
            pre_q       <= '0;
            post_q      <= '0;
            captureWrEn <= 1'b0;
            captureAddr <= '0;
            triggerAddr <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            donePulse   <= 1'b0;
            forced      <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            captureWrEn <= wr;
            busy        <= (state_nx == PREFILL) || (state_nx == ARMED) ||
                           (state_nx == POST);
            done        <= (state_nx == DONE);
            donePulse   <= enter_done;
            if (latch) begin
                pre_q  <= pre_c;
                post_q <= postCount;
            end
            if (wr) begin
                captureAddr <= ptr;
                ptr         <= ptr + ONE;
            end
            if (trig) begin
                triggerAddr <= ptr;
                forced      <= forceTrigger;
            end
        end
    end

`ifdef ADC_CAPTURE_AUTO_REARM_EN
    always_ff @(posedge adcClk or negedge adcReset_n) begin
        if (!adcReset_n) begin
            hold <= '0;
        end else if (enter_done) begin
            hold <= holdoff;
        end else if ((state == DONE) && (hold != '0)) begin
            hold <= hold - HONE;
        end
    end
`endif

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Bench for adc_capture_sequencer: capture table, corner sequences, random vs model.
// Honours ADC_CAPTURE_AUTO_REARM_EN the same way as the design.
module tb_adc_capture_sequencer;

    localparam int AW = 10;
    localparam int HW = 16;
    localparam int D  = 1 << AW;

    logic          adcClk = 1'b0;
    logic          adcReset_n;
    logic          arm, abort, forceTrigger;
    logic [AW-1:0] preCount, postCount;
    logic [HW-1:0] holdoff;
    logic          adcValidOut, adcUseThisSample, adcExceedsThreshold;
    logic          captureWrEn;
    logic [AW-1:0] captureAddr, triggerAddr;
    logic          busy, done, donePulse, forced;

    adc_capture_sequencer #(.ADDR_WIDTH(AW), .HOLDOFF_WIDTH(HW)) dut (
        .adcClk(adcClk), .adcReset_n(adcReset_n), .arm(arm), .abort(abort),
        .forceTrigger(forceTrigger), .preCount(preCount), .postCount(postCount),
        .holdoff(holdoff), .adcValidOut(adcValidOut),
        .adcUseThisSample(adcUseThisSample),
        .adcExceedsThreshold(adcExceedsThreshold), .captureWrEn(captureWrEn),
        .captureAddr(captureAddr), .triggerAddr(triggerAddr), .busy(busy),
        .done(done), .donePulse(donePulse), .forced(forced)
    );

    always #5 adcClk = ~adcClk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: phase plus countdowns of samples still owed
    localparam int P_IDLE = 0, P_FILL = 1, P_WAIT = 2, P_TAIL = 3, P_DONE = 4;
    int m_phase, m_ptr, m_pre, m_post, m_pre_left, m_post_left, m_hold_left;
    int m_wr, m_addr, m_trig, m_busy, m_done, m_pulse, m_forced;

    task automatic model_reset();
        m_phase = P_IDLE; m_ptr = 0; m_pre = 0; m_post = 0;
        m_pre_left = 0; m_post_left = 0; m_hold_left = 0;
        m_wr = 0; m_addr = 0; m_trig = 0; m_busy = 0;
        m_done = 0; m_pulse = 0; m_forced = 0;
    endtask

    task automatic load_cfg();
        m_post = int'(postCount);
        m_pre  = (int'(preCount) > D - 1 - m_post) ? D - 1 - m_post : int'(preCount);
        m_pre_left = m_pre;
    endtask

    task automatic model_step();
        int  nxt;
        bit  w, t, qual;
        if (!adcReset_n) begin
            model_reset();
            return;
        end
        nxt  = m_phase;
        w    = 0;
        t    = 0;
        qual = adcValidOut && adcUseThisSample && adcExceedsThreshold;
        if (abort) nxt = P_IDLE;
        else case (m_phase)
            P_IDLE: if (arm) begin load_cfg(); nxt = P_FILL; end
            P_FILL: begin
                w = adcValidOut;
                if (w) m_pre_left--;
                if (m_pre_left <= 0) nxt = P_WAIT;
            end
            P_WAIT: begin
                w = adcValidOut;
                if (qual || forceTrigger) begin
                    t = 1;
                    m_post_left = m_post;
                    nxt = (m_post == 0) ? P_DONE : P_TAIL;
                end
            end
            P_TAIL: begin
                w = adcValidOut;
                if (w) m_post_left--;
                if (m_post_left == 0) nxt = P_DONE;
            end
            default: begin
                if (arm) begin load_cfg(); nxt = P_FILL; end
`ifdef ADC_CAPTURE_AUTO_REARM_EN
                else if (m_hold_left == 0) begin m_pre_left = m_pre; nxt = P_FILL; end
                else m_hold_left--;
`endif
            end
        endcase
        if (t) begin
            m_trig   = m_ptr;
            m_forced = forceTrigger;
        end
        m_wr = w;
        if (w) begin
            m_addr = m_ptr;
            m_ptr  = (m_ptr + 1) % D;
        end
        m_pulse = (nxt == P_DONE) && (m_phase != P_DONE);
        if (m_pulse) m_hold_left = int'(holdoff);
        m_done  = (nxt == P_DONE);
        m_busy  = (nxt == P_FILL) || (nxt == P_WAIT) || (nxt == P_TAIL);
        m_phase = nxt;
    endtask

    task automatic tick();
        model_step();
        @(posedge adcClk);
        #1;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(string tag);
        check({tag, ".wr"},     32'(captureWrEn), 32'(m_wr));
        check({tag, ".addr"},   32'(captureAddr), 32'(m_addr));
        check({tag, ".trig"},   32'(triggerAddr), 32'(m_trig));
        check({tag, ".busy"},   32'(busy),        32'(m_busy));
        check({tag, ".done"},   32'(done),        32'(m_done));
        check({tag, ".pulse"},  32'(donePulse),   32'(m_pulse));
        check({tag, ".forced"}, 32'(forced),      32'(m_forced));
    endtask

    task automatic quiet();
        arm = 0; abort = 0; forceTrigger = 0;
        adcValidOut = 0; adcUseThisSample = 0; adcExceedsThreshold = 0;
    endtask

    task automatic go_idle();
        quiet();
        abort = 1;
        tick();
        abort = 0;
    endtask

    task automatic start(int pre, int post);
        preCount = AW'(pre); postCount = AW'(post);
        arm = 1;
        tick();
        arm = 0;
    endtask

    task automatic advance_to(int target);
        int n;
        go_idle();
        n = (target - m_ptr + D) % D;
        if (n == 0) return;
        start(0, 0);
        adcValidOut = 1;
        repeat (n) tick();
        go_idle();
    endtask

    typedef struct {
        int pre; int post; int early; int trig_at; bit frc;
        int exp_off; int exp_writes; bit exp_forced;
    } vec_t;

    vec_t vecs[7];

    task automatic run_vec(int idx, vec_t v);
        int p0, nw, first;
        bit got;
        go_idle();
        p0 = m_ptr; nw = 0; first = -1; got = 0;
        start(v.pre, v.post);
        for (int c = 1; c <= 3000 && !got; c++) begin
            adcValidOut         = 1;
            adcUseThisSample    = 1;
            adcExceedsThreshold = (c == v.early) || (c == v.trig_at && !v.frc);
            forceTrigger        = (c == v.trig_at) && v.frc;
            tick();
            if (captureWrEn) begin
                if (nw == 0) first = int'(captureAddr);
                nw++;
            end
            if (done) got = 1;
        end
        quiet();
        check($sformatf("vec%0d.done", idx), 32'(got), 32'd1);
        check($sformatf("vec%0d.writes", idx), 32'(nw), 32'(v.exp_writes));
        check($sformatf("vec%0d.first", idx), 32'(first), 32'(p0));
        check($sformatf("vec%0d.trigaddr", idx), 32'(triggerAddr),
              32'((p0 + v.exp_off) % D));
        check($sformatf("vec%0d.forced", idx), 32'(forced), 32'(v.exp_forced));
        go_idle();
    endtask

    int wrap_exp[8] = '{1020, 1021, 1022, 1023, 0, 1, 2, 3};

    initial begin
        int p0, k;
        bit seen;
        vecs[0] = '{4,    3,    0, 10, 1'b0, 9,  13,   1'b0};
        vecs[1] = '{8,    2,    3, 12, 1'b0, 11, 14,   1'b0};
        vecs[2] = '{0,    0,    0, 2,  1'b0, 1,  2,    1'b0};
        vecs[3] = '{2,    5,    0, 6,  1'b1, 5,  11,   1'b1};
        vecs[4] = '{1000, 1000, 0, 30, 1'b0, 29, 1030, 1'b0};
        vecs[5] = '{5,    1,    0, 6,  1'b0, 5,  7,    1'b0};
        vecs[6] = '{5,    1,    5, 9,  1'b0, 8,  10,   1'b0};

        quiet();
        preCount = '0; postCount = '0; holdoff = '0;
        adcReset_n = 0;
        model_reset();
        tick();
        tick();
        adcReset_n = 1;

        // reset state, then idle with a toggling strobe
        check("rst.wr", 32'(captureWrEn), 0);
        check("rst.addr", 32'(captureAddr), 0);
        check("rst.trig", 32'(triggerAddr), 0);
        check("rst.busy", 32'(busy), 0);
        check("rst.done", 32'(done), 0);
        check("rst.pulse", 32'(donePulse), 0);
        check("rst.forced", 32'(forced), 0);
        for (int i = 0; i < 10; i++) begin
            adcValidOut = i[0];
            adcUseThisSample = 1;
            adcExceedsThreshold = 1;
            tick();
            check("idle.wr", 32'(captureWrEn), 0);
            check("idle.busy", 32'(busy), 0);
        end
        quiet();

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // force with no sample strobe, post = 0
        holdoff = 16'd100;
        go_idle();
        p0 = m_ptr;
        start(0, 0);
        tick();
        forceTrigger = 1;
        tick();
        forceTrigger = 0;
        check("frc.done", 32'(done), 1);
        check("frc.pulse", 32'(donePulse), 1);
        check("frc.forced", 32'(forced), 1);
        check("frc.wr", 32'(captureWrEn), 0);
        check("frc.trigaddr", 32'(triggerAddr), 32'(p0));
        tick();
        check("frc.pulse2", 32'(donePulse), 0);
        check("frc.done2", 32'(done), 1);
        check("frc.wr2", 32'(captureWrEn), 0);

        // pointer wrap across the top of the buffer
        advance_to(1020);
        start(2, 5);
        adcValidOut = 1;
        adcUseThisSample = 1;
        for (int c = 1; c <= 8; c++) begin
            adcExceedsThreshold = (c == 3);
            tick();
            check("wrap.wr", 32'(captureWrEn), 1);
            check("wrap.addr", 32'(captureAddr), 32'(wrap_exp[c-1]));
        end
        quiet();
        check("wrap.done", 32'(done), 1);
        check("wrap.trigaddr", 32'(triggerAddr), 32'd1022);

        // abort in the middle of the post-trigger phase
        go_idle();
        p0 = m_ptr;
        start(0, 10);
        adcValidOut = 1;
        adcUseThisSample = 1;
        tick();
        adcExceedsThreshold = 1;
        tick();
        adcExceedsThreshold = 0;
        repeat (3) tick();
        check("abort.busy0", 32'(busy), 1);
        abort = 1;
        tick();
        abort = 0;
        check("abort.busy", 32'(busy), 0);
        check("abort.done", 32'(done), 0);
        check("abort.pulse", 32'(donePulse), 0);
        check("abort.trigaddr", 32'(triggerAddr), 32'((p0 + 1) % D));
        seen = 0;
        repeat (5) begin
            tick();
            if (donePulse || captureWrEn) seen = 1;
        end
        check("abort.quiet", 32'(seen), 0);
        quiet();

        // arm and abort together: abort wins
        arm = 1; abort = 1;
        tick();
        quiet();
        check("armabort.busy", 32'(busy), 0);

`ifdef ADC_CAPTURE_AUTO_REARM_EN
        holdoff = 16'd5;
        go_idle();
        start(0, 0);
        adcValidOut = 1; adcUseThisSample = 1; adcExceedsThreshold = 1;
        tick();
        tick();
        quiet();
        check("hold.pulse", 32'(donePulse), 1);
        k = 0;
        for (int i = 1; i <= 20 && k == 0; i++) begin
            tick();
            if (busy) k = i;
        end
        check("hold.cycles", 32'(k), 32'd6);
        go_idle();
`endif

        // asynchronous reset in mid-capture
        go_idle();
        start(3, 3);
        adcValidOut = 1;
        repeat (4) tick();
        #2 adcReset_n = 0;
        #1;
        check("arst.wr", 32'(captureWrEn), 0);
        check("arst.addr", 32'(captureAddr), 0);
        check("arst.trig", 32'(triggerAddr), 0);
        check("arst.busy", 32'(busy), 0);
        check("arst.done", 32'(done), 0);
        check("arst.pulse", 32'(donePulse), 0);
        check("arst.forced", 32'(forced), 0);
        quiet();
        tick();
        adcReset_n = 1;

        // random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            arm          = ($urandom_range(0, 19) == 0);
            abort        = ($urandom_range(0, 99) == 0);
            forceTrigger = ($urandom_range(0, 39) == 0);
            adcValidOut  = ($urandom_range(0, 3) != 0);
            adcUseThisSample    = 1'($urandom_range(0, 1));
            adcExceedsThreshold = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 9) == 0) preCount = AW'($urandom_range(0, D - 1));
            else preCount = AW'($urandom_range(0, 12));
            if ($urandom_range(0, 19) == 0) postCount = AW'($urandom_range(0, D - 1));
            else postCount = AW'($urandom_range(0, 12));
            holdoff = HW'($urandom_range(0, 6));
            tick();
            check_all("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
